// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer plus prefetch FIFO feeding decode; optional FETCH_PERF_CNT_EN adds fetch/flush counters.
// Latency: Start at edge N -> first entry at edge N+1; a Redirect leaves InstrValid low for one cycle, then the target arrives.
// Backpressure: fetch stalls when the FIFO is full and decode does not pop; full+pop refills the same cycle.

// sync_fifo: generic DEPTH-entry FIFO with synchronous flush; head is combinational from storage.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: the caller never pushes when full without a simultaneous pop, and never pops when empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); flush empties in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          DEPTH     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [31:0] ImAddress,
    input  logic [31:0] ImInstruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic        Busy,
    output logic        Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [15:0] FlushCount
`endif
);
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          push, flush, pop;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_ent, head_ent, hold_ent, out_ent;
    logic          fifo_full, can_fetch, in_range;

    assign push_ent  = '{pc: pc, instr: ImInstruction};
    assign pop       = InstrValid & InstrReady;
    assign fifo_full = (fifo_count == CW'(DEPTH));
    assign can_fetch = !fifo_full || pop;
    assign in_range  = (pc < PC_LIMIT);

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rst      (Reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_ent),
        .count    (fifo_count)
    );

    // State and PC registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next state, next PC and push/flush; Redirect outranks everything but Reset.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        flush     = 1'b0;
        if (Redirect) begin
            flush  = 1'b1;
            pc_nxt = RedirectTarget & 32'hFFFF_FFFC;
            if (state != ST_IDLE) state_nxt = ST_RUN;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (Start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // Out-of-range words are never captured.
                    if (!in_range) begin
                        state_nxt = ST_HALT;
                    end else if (can_fetch) begin
                        push   = 1'b1;
                        pc_nxt = pc + 32'd4;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Remember the last displayed entry so the outputs hold while the FIFO is empty.
    always_ff @(posedge Clk) begin
        if (Reset) hold_ent <= '0;
        else       hold_ent <= out_ent;
    end

    assign out_ent    = (fifo_count != '0) ? head_ent : hold_ent;
    assign InstrValid = (fifo_count != '0);
    assign InstrOut   = out_ent.instr;
    assign InstrPC    = out_ent.pc;
    assign ImAddress  = pc;
    assign Busy       = (state == ST_RUN);
    assign Halted     = (state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic drop_any;
    // A same-cycle pop is consumed by decode, so only entries beyond it count as dropped.
    assign drop_any = (fifo_count > CW'(pop));

    // Saturating performance counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (push && (FetchCount != '1)) FetchCount <= FetchCount + 32'd1;
            if (Redirect && drop_any && (FlushCount != '1)) FlushCount <= FlushCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random traffic against a queue-based reference model.
// Latency: outputs sampled on the falling edge, inputs driven right after it.
// Backpressure: InstrReady is toggled directed and at random.
module tb_fetch_sequencer;
    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] LIMIT     = 32'(MEM_WORDS) * 32'd4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, start, redirect, instr_ready;
    logic [31:0] redirect_target, im_address, im_instruction, instr_out, instr_pc;
    logic        instr_valid, busy, halted;
    logic [31:0] mem [MEM_WORDS];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;

    ent_t        q[$];
    ent_t        last;
    logic [31:0] ref_pc;
    int          mode;
    logic [31:0] ref_fcnt;
    logic [15:0] ref_flcnt;

    always #5 clk = ~clk;

    assign im_instruction = (im_address < LIMIT) ? mem[im_address[11:2]] : 32'hBAD0_BAD0;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS),
        .DEPTH     (DEPTH)
    ) dut (
        .Clk            (clk),
        .Reset          (reset),
        .Start          (start),
        .ImAddress      (im_address),
        .ImInstruction  (im_instruction),
        .Redirect       (redirect),
        .RedirectTarget (redirect_target),
        .InstrValid     (instr_valid),
        .InstrReady     (instr_ready),
        .InstrOut       (instr_out),
        .InstrPC        (instr_pc),
        .Busy           (busy),
        .Halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount     (fetch_count),
        .FlushCount     (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: advances one clock edge using the inputs currently driven.
    task automatic model_step();
        logic do_pop;
        if (reset) begin
            q.delete();
            ref_pc    = RESET_PC;
            mode      = M_IDLE;
            last      = '0;
            ref_fcnt  = '0;
            ref_flcnt = '0;
            return;
        end
        do_pop = (q.size() > 0) && instr_ready;
        if (q.size() > 0) last = q[0];
        if (redirect) begin
            if (q.size() > (do_pop ? 1 : 0) && ref_flcnt != 16'hFFFF) ref_flcnt++;
            q.delete();
            ref_pc = {redirect_target[31:2], 2'b00};
            if (mode != M_IDLE) mode = M_RUN;
            return;
        end
        if (do_pop) void'(q.pop_front());
        if (mode == M_IDLE) begin
            if (start) mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (ref_pc >= LIMIT) begin
                mode = M_HALT;
            end else if (q.size() < DEPTH) begin
                q.push_back('{pc: ref_pc, ins: mem[ref_pc[11:2]]});
                ref_pc = ref_pc + 32'd4;
                if (ref_fcnt != 32'hFFFF_FFFF) ref_fcnt++;
            end
        end
    endtask

    task automatic check_all();
        ent_t e;
        e = (q.size() > 0) ? q[0] : last;
        chk("valid",  instr_valid, (q.size() > 0) ? 32'd1 : 32'd0);
        chk("instr",  instr_out, e.ins);
        chk("ipc",    instr_pc, e.pc);
        chk("busy",   busy, (mode == M_RUN) ? 32'd1 : 32'd0);
        chk("halted", halted, (mode == M_HALT) ? 32'd1 : 32'd0);
        chk("imaddr", im_address, ref_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("fetchcnt", fetch_count, ref_fcnt);
        chk("flushcnt", 32'(flush_count), 32'(ref_flcnt));
`endif
    endtask

    task automatic cycle(input logic rst, input logic st, input logic rd,
                         input logic [31:0] tgt, input logic rdy);
        reset = rst; start = st; redirect = rd; redirect_target = tgt; instr_ready = rdy;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = i * 3;

        // Reset state
        repeat (3) cycle(1, 0, 0, 0, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", im_address, RESET_PC);

        // 1: streaming, one instruction per cycle
        cycle(0, 1, 0, 0, 1);
        chk("t1_busy", busy, 1);
        chk("t1_novalid", instr_valid, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 0, 1);
            chk("t1_ipc", instr_pc, 32'(k * 4));
            chk("t1_ins", instr_out, 32'(k * 3));
        end

        // 2: backpressure fills exactly DEPTH entries, then resumes without gaps
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        chk("t2_pc", im_address, 32'd8);
        chk("t2_ins", instr_out, 32'd0);
        chk("t2_valid", instr_valid, 1);
        cycle(0, 0, 0, 0, 1);
        chk("t2_ipc4", instr_pc, 32'd4);
        chk("t2_ins4", instr_out, 32'd3);
        cycle(0, 0, 0, 0, 1);
        chk("t2_ipc8", instr_pc, 32'd8);

        // 3: redirect with a full FIFO, low bits forced to zero
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h103, 0);
        chk("t3_flush", instr_valid, 0);
        chk("t3_pc", im_address, 32'h100);
        cycle(0, 0, 0, 0, 1);
        chk("t3_ipc", instr_pc, 32'h100);
        chk("t3_ins", instr_out, 32'd192);

        // 4: run off the end of memory, halt, drain, restart by redirect
        cycle(0, 0, 1, 32'hFF8, 1);
        cycle(0, 0, 0, 0, 1);
        chk("t4_ipc0", instr_pc, 32'hFF8);
        chk("t4_ins0", instr_out, 32'd3066);
        cycle(0, 0, 0, 0, 1);
        chk("t4_ipc1", instr_pc, 32'hFFC);
        cycle(0, 0, 0, 0, 1);
        chk("t4_halted", halted, 1);
        chk("t4_drained", instr_valid, 0);
        chk("t4_hold", instr_out, 32'd3069);
        chk("t4_nofetch", im_address, 32'h1000);
        cycle(0, 1, 0, 0, 1);
        chk("t4_startign", halted, 1);
        cycle(0, 0, 1, 32'h0, 1);
        chk("t4_busy", busy, 1);
        cycle(0, 0, 0, 0, 1);
        chk("t4_resume", instr_pc, 32'h0);

        // 5: reset while full
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("t5_valid", instr_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pc", im_address, RESET_PC);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("t5_restart", instr_pc, RESET_PC);

        // Random traffic against the model
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        cycle(1, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic        r_rst, r_st, r_rd, r_rdy;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 9) == 0);
            r_rd  = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       r_tgt = $urandom & 32'h0000_0FFF;
                1:       r_tgt = 32'hFE0 + 32'($urandom_range(0, 31));
                2:       r_tgt = $urandom;
                default: r_tgt = 32'h0;
            endcase
            cycle(r_rst, r_st, r_rd, r_tgt, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
